vector_split_rx: RTL and testbench
==================================

# vector_split_rx

Receive-side counterpart of the 5-bit-field packer. It accepts the packed 32-bit frame as a stream of four bytes over a valid/ready handshake and reassembles it. It unpacks the frame back into six 5-bit fields, checks the 2-bit `11` trailer, and presents the result on a registered valid/ready output port. It sits between a byte-wide link and any consumer of the six fields.

## Interface
Parameters:
- none; all field widths are fixed (6 × 5-bit fields + 2-bit trailer = 32 bits = 4 bytes).

Ports:
- One clock; reset is synchronous and active-high.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `byte_in`  input  8  incoming byte; the first byte of a frame carries frame bits [31:24].
- `byte_valid`  input  1  `byte_in` is valid this cycle.
- `byte_ready`  output  1  block can accept a byte this cycle.
- `sync`  input  1  discard any partially collected frame.
- `a`, `b`, `c`, `d`, `e`, `f`  output  5 each  unpacked fields (registered).
- `out_valid`  output  1  fields and `frame_err` are valid.
- `out_ready`  input  1  consumer accepts the fields.
- `frame_err`  output  1  trailer bits [1:0] of the frame were not `2'b11`.
- `frame_cnt`  output  8  count of frames delivered; wraps 255 → 0.

## Operation
- Frame layout: {a, b, c, d, e, f, 2'b11} = {byte0, byte1, byte2, byte3}.
- Field mapping into the assembled word:
  - a = [31:27], b = [26:22], c = [21:17]
  - d = [16:12], e = [11:7], f = [6:2]
  - trailer = [1:0]
- The FSM has two states, COLLECT and OUT.
- COLLECT:
  - `byte_ready` = 1.
  - A 2-bit byte index `idx` selects the destination byte lane.
  - On each accept (`byte_valid && byte_ready`), the byte is stored into lane `idx` and `idx` increments.
  - On the accept with `idx` = 3: load a..f from the assembled word (byte3 taken directly from `byte_in`), set `frame_err` = (`byte_in[1:0]` != `2'b11`), set `out_valid` = 1, set `idx` = 0, go to OUT.
- OUT:
  - `byte_ready` = 0.
  - a..f and `frame_err` are held stable while `out_valid` = 1 and `out_ready` = 0.
  - On `out_valid && out_ready`: clear `out_valid`, increment `frame_cnt` (mod 256), go to COLLECT.
- `byte_ready` is decoded from the state only. It does not depend on `byte_valid`.
- `sync`:
  - In COLLECT, it forces `idx` to 0, and any byte presented in the same cycle is discarded. `sync` has priority over the accept.
  - In OUT, it has no effect.
- A frame with a bad trailer is still delivered. Only `frame_err` flags it. The fields are unpacked as received.
- `frame_err` keeps its value after delivery and is updated only when the next frame completes.

## Timing
- Reset values:
  - state = COLLECT, `idx` = 0
  - `byte_ready` = 1 during and after reset
  - `out_valid` = 0
  - a..f = 0
  - `frame_err` = 0
  - `frame_cnt` = 0
- `rst` mid-frame drops the partial frame. `rst` while in OUT drops the pending output without counting it.
- Latency: `out_valid` rises on the same clock edge that accepts byte 3, so it is visible in the cycle after the byte-3 handshake.
- Return to COLLECT: `byte_ready` returns to 1 in the cycle after the output handshake.
- Maximum throughput is one frame per 5 cycles (4 collect + 1 out) when `byte_valid` and `out_ready` are held high.
- Gaps (`byte_valid` = 0) may occur between any bytes. `idx` holds its value through them.
- All outputs are registered or state-decoded. There is no combinational path from any input to any output.

## Test plan
- Frame 1, reset behaviour:
  - Stimulus: reset, then bytes 00, 00, 00, 07 back-to-back with `out_ready` = 1.
  - Required response: `out_valid` for one cycle with a..e = 00, f = 01, `frame_err` = 0, `frame_cnt` 0 → 1.
- Frame 2, field mapping:
  - Stimulus: bytes 97, CA, 86, 8B.
  - Required response: a = 12, b = 1F, c = 05, d = 08, e = 0D, f = 02, `frame_err` = 0.
- Backpressure:
  - Stimulus: frame 2 with `out_ready` = 0 for 6 cycles.
  - Required response: `out_valid` and the fields stay stable, `byte_ready` = 0, and a byte offered during the stall is not consumed. After `out_ready` = 1, `frame_cnt` increments exactly once.
- Bad trailer:
  - Stimulus: bytes 97, CA, 86, 88.
  - Required response: the same a..f as frame 2, `frame_err` = 1. The next good frame clears `frame_err` to 0.
- Resync and reset mid-frame:
  - Stimulus: bytes 97, CA, then `sync` (with FF offered in the same cycle), then 00, 00, 00, 07.
  - Required response: a..e = 0, f = 01.
  - Also required: a repeat of the sequence using `rst` instead of `sync` gives the same fields and `frame_cnt` = 1.
- Gapped input and wrap:
  - Stimulus: frame 2 with 3 idle cycles between bytes.
  - Required response: identical output to the back-to-back case.
  - Also required: 256 frames return `frame_cnt` to 0.

Source files
------------

// File: rtl/vector_split_rx.sv
// rtl/vector_split_rx.sv - byte-stream receiver that reassembles a 32-bit frame into six 5-bit fields
//
// Purpose:
//   Collects four bytes (first byte = frame bits [31:24]) over a valid/ready
//   handshake, unpacks {a,b,c,d,e,f,2'b11} and presents the fields on a
//   registered valid/ready output. A bad trailer is flagged, not dropped.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   byte_in    incoming byte
//   byte_valid byte_in valid
//   byte_ready block accepts a byte (state-decoded)
//   sync       discard partially collected frame (COLLECT only)
//   a..f       unpacked 5-bit fields (registered)
//   out_valid  fields and frame_err valid
//   out_ready  consumer accepts the fields
//   frame_err  trailer bits were not 2'b11
//   frame_cnt  delivered frame count, wraps 255 -> 0

module vector_split_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       sync,
    output logic [4:0] a,
    output logic [4:0] b,
    output logic [4:0] c,
    output logic [4:0] d,
    output logic [4:0] e,
    output logic [4:0] f,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic [7:0] frame_cnt
);

    typedef enum logic {
        COLLECT = 1'b0,
        OUT     = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  idx;
    logic [7:0]  byte0;
    logic [7:0]  byte1;
    logic [7:0]  byte2;
    logic [31:0] word;
    logic        accept;
    logic        deliver;

    // The last byte is taken straight from the input so the fields load on
    // the same edge that accepts it.
    assign word = {byte0, byte1, byte2, byte_in};

    assign byte_ready = (state == COLLECT);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        deliver    = 1'b0;
        case (state)
            COLLECT: begin
                // sync wins over a byte offered in the same cycle
                accept = byte_valid && !sync;
                if (accept && (idx == 2'd3)) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                deliver = out_valid && out_ready;
                if (deliver) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            idx       <= 2'd0;
            byte0     <= 8'd0;
            byte1     <= 8'd0;
            byte2     <= 8'd0;
            a         <= 5'd0;
            b         <= 5'd0;
            c         <= 5'd0;
            d         <= 5'd0;
            e         <= 5'd0;
            f         <= 5'd0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            state <= state_next;

            if (state == COLLECT && sync) begin
                idx <= 2'd0;
            end else if (accept) begin
                case (idx)
                    2'd0:    byte0 <= byte_in;
                    2'd1:    byte1 <= byte_in;
                    2'd2:    byte2 <= byte_in;
                    default: begin
                        a         <= word[31:27];
                        b         <= word[26:22];
                        c         <= word[21:17];
                        d         <= word[16:12];
                        e         <= word[11:7];
                        f         <= word[6:2];
                        frame_err <= (word[1:0] != 2'b11);
                        out_valid <= 1'b1;
                    end
                endcase
                idx <= idx + 2'd1;
            end

            if (deliver) begin
                out_valid <= 1'b0;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vector_split_rx.sv
// tb/tb_vector_split_rx.sv - directed self-checking bench for vector_split_rx

module tb_vector_split_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       sync;
    logic [4:0] a, b, c, d, e, f;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic [7:0] frame_cnt;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_cnt;

    always #5 clk = ~clk;

    vector_split_rx dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .sync       (sync),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .e          (e),
        .f          (f),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and hold it until the handshake edge; optional idle gap after.
    task automatic send_byte(input logic [7:0] bv, input int gap);
        int n;
        n = 0;
        byte_in    = bv;
        byte_valid = 1'b1;
        while (!byte_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("byte_ready_timeout", 32'd0, 32'd1);
        step();
        byte_valid = 1'b0;
        for (int i = 0; i < gap; i++) step();
    endtask

    task automatic send_frame(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8],  gap);
        send_byte(w[7:0],   0);
    endtask

    // Wait for out_valid, check the held fields, complete the handshake.
    task automatic expect_frame(input string tag, input logic [29:0] fld, input logic err);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check({tag, "_valid_timeout"}, 32'd0, 32'd1);
        check({tag, "_fields"}, {2'b0, a, b, c, d, e, f}, {2'b0, fld});
        check({tag, "_err"}, {31'd0, frame_err}, {31'd0, err});
        check({tag, "_cnt_before"}, {24'd0, frame_cnt}, {24'd0, exp_cnt});
        check({tag, "_ready_low"}, {31'd0, byte_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        exp_cnt = exp_cnt + 8'd1;
        check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_cnt_after"}, {24'd0, frame_cnt}, {24'd0, exp_cnt});
        check({tag, "_ready_back"}, {31'd0, byte_ready}, 32'd1);
        check({tag, "_err_held"}, {31'd0, frame_err}, {31'd0, err});
    endtask

    localparam logic [31:0] FRAME1 = 32'h0000_0007;
    localparam logic [29:0] FLD1   = {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h01};
    localparam logic [31:0] FRAME2 = 32'h97CA_868B;
    localparam logic [31:0] FRAMEB = 32'h97CA_8688;
    localparam logic [29:0] FLD2   = {5'h12, 5'h1F, 5'h05, 5'h08, 5'h0D, 5'h02};

    initial begin
        rst        = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        sync       = 1'b0;
        out_ready  = 1'b1;
        exp_cnt    = 8'd0;
        step();
        step();
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd1);
        rst = 1'b0;
        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_fields", {2'b0, a, b, c, d, e, f}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_cnt", {24'd0, frame_cnt}, 32'd0);
        check("rst_byte_ready2", {31'd0, byte_ready}, 32'd1);

        // Frame 1 back-to-back: out_valid visible right after byte-3 handshake
        send_frame(FRAME1, 0);
        check("f1_latency", {31'd0, out_valid}, 32'd1);
        expect_frame("f1", FLD1, 1'b0);

        // Frame 2 field mapping
        send_frame(FRAME2, 0);
        expect_frame("f2", FLD2, 1'b0);

        // Backpressure with a byte offered during the stall
        out_ready = 1'b0;
        send_frame(FRAME2, 0);
        byte_in    = 8'h55;
        byte_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_fields", {2'b0, a, b, c, d, e, f}, {2'b0, FLD2});
            check("bp_ready", {31'd0, byte_ready}, 32'd0);
            check("bp_cnt", {24'd0, frame_cnt}, {24'd0, exp_cnt});
            step();
        end
        byte_valid = 1'b0;
        expect_frame("bp", FLD2, 1'b0);
        step();
        check("bp_cnt_once", {24'd0, frame_cnt}, {24'd0, exp_cnt});
        // If the stalled byte had been taken, this frame would be misaligned
        send_frame(FRAME1, 0);
        expect_frame("bp_next", FLD1, 1'b0);

        // Bad trailer delivered and flagged; next good frame clears it
        send_frame(FRAMEB, 0);
        expect_frame("bad", FLD2, 1'b1);
        send_frame(FRAME2, 0);
        expect_frame("bad_clear", FLD2, 1'b0);

        // Resync mid-frame with FF offered alongside sync
        send_byte(8'h97, 0);
        send_byte(8'hCA, 0);
        sync       = 1'b1;
        byte_in    = 8'hFF;
        byte_valid = 1'b1;
        step();
        sync       = 1'b0;
        byte_valid = 1'b0;
        send_frame(FRAME1, 0);
        expect_frame("sync", FLD1, 1'b0);

        // Reset mid-frame
        send_byte(8'h97, 0);
        send_byte(8'hCA, 0);
        rst = 1'b1;
        step();
        rst     = 1'b0;
        exp_cnt = 8'd0;
        check("midrst_cnt", {24'd0, frame_cnt}, 32'd0);
        send_frame(FRAME1, 0);
        expect_frame("midrst", FLD1, 1'b0);
        check("midrst_cnt1", {24'd0, frame_cnt}, 32'd1);

        // Reset while output pending drops it without counting
        out_ready = 1'b0;
        send_frame(FRAME2, 0);
        rst = 1'b1;
        step();
        rst     = 1'b0;
        exp_cnt = 8'd0;
        check("outrst_valid", {31'd0, out_valid}, 32'd0);
        check("outrst_cnt", {24'd0, frame_cnt}, 32'd0);
        check("outrst_ready", {31'd0, byte_ready}, 32'd1);
        out_ready = 1'b1;

        // Gapped input gives the same output as back-to-back
        send_frame(FRAME2, 3);
        expect_frame("gap", FLD2, 1'b0);

        // Wrap: 256 frames from reset return frame_cnt to 0
        rst = 1'b1;
        step();
        rst     = 1'b0;
        exp_cnt = 8'd0;
        for (int k = 0; k < 256; k++) begin
            send_frame(FRAME2, 0);
            expect_frame("wrap", FLD2, 1'b0);
        end
        check("wrap_zero", {24'd0, frame_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
